// File: rtl/mdu_hilo.sv
// Multicycle MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, one radix-2 step per cycle.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] crs,
  input  logic [WIDTH-1:0] crt,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r;
  logic [WIDTH-1:0] b_mag, acc_hi, acc_lo;

  logic             accept, signed_op, zero_div, crs_neg, crt_neg, last;
  logic [WIDTH-1:0] crs_mag, crt_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign accept    = start && (state != RUN);
  assign signed_op = ~md_op[0];
  assign zero_div  = accept && md_op[1] && (crt == '0);
  assign crs_neg   = signed_op && crs[WIDTH-1];
  assign crt_neg   = signed_op && crt[WIDTH-1];
  assign crs_mag   = crs_neg ? -crs : crs;
  assign crt_mag   = crt_neg ? -crt : crt;
  assign last      = (cnt == CNT_W'(WIDTH-1));

  // acc_lo holds the multiplier / dividend and shifts out one bit per step;
  // b_mag holds the multiplicand / divisor.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_mag};

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  assign prod   = {step_hi, step_lo};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_nx = zero_div ? FIN : RUN;
        else       state_nx = IDLE;
      end
      RUN:     if (last) state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_mag       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (accept) begin
      cnt         <= '0;
      is_div      <= md_op[1];
      neg_q       <= crs_neg ^ crt_neg;
      neg_r       <= crs_neg;
      acc_hi      <= '0;
      acc_lo      <= md_op[1] ? crs_mag : crt_mag;
      b_mag       <= md_op[1] ? crt_mag : crs_mag;
      div_by_zero <= zero_div;
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last) begin
        if (is_div) begin
          lo <= neg_q ? -step_lo : step_lo;
          hi <= neg_r ? -step_hi : step_hi;
        end else begin
          {hi, lo} <= prod_s;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: sequencer pushes expected results, monitor checks on done.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] crs = '0, crt = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .crs(crs), .crt(crt),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: counts busy cycles since the last done and checks each result.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          chk("busy_cycles", busy_cnt, e.busy_cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int ebusy);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.busy_cyc = ebusy;
    exp_q.push_back(e);
    start = 1'b1; md_op = op; crs = a; crt = b;
    @(posedge clk); #1;
    start = 1'b0; crs = 32'hDEAD_BEEF; crt = 32'h0BAD_F00D; md_op = 2'b10;
  endtask

  // Stops at the negedge where done is high, so a caller can issue in FIN.
  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_total++;
    $display("FAIL wait_done: got no done within 100 cycles expected done");
  endtask

  task automatic drain();
    wait_done();
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #15;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
    #5 rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32);
    drain();
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    drain();

    // DIV then DIVU issued in the FIN cycle
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    wait_done();
    issue(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 32);
    drain();

    // Load hi/lo = 0x1111/0x2222, then divide by zero
    issue(2'b11, 32'h0444_5111, 32'h0000_2000, 32'h0000_1111, 32'h0000_2222, 1'b0, 32);
    drain();
    issue(2'b11, 32'h1234_5678, 32'h0, 32'h0000_1111, 32'h0000_2222, 1'b1, 0);
    drain();
    chk("dbz_sticky", {31'b0, div_by_zero}, 32'h1);
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 32);
    drain();

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 32);
    drain();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 32);
    drain();

    // Re-pulsed start mid-operation must be ignored
    issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 32);
    repeat (9) @(negedge clk);
    start = 1'b1; md_op = 2'b00; crs = 32'hFFFF_FFFF; crt = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Reset in the middle of a DIV discards it
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
